// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle controller
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Values shared with the IFU next-PC mux
    localparam logic [1:0] NPC_SEL_PC4 = 2'b00;
    localparam logic [1:0] NPC_SEL_REG = 2'b01;
    localparam logic [1:0] NPC_SEL_J   = 2'b10;
    localparam logic [1:0] NPC_SEL_BEQ = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] WDSEL_ALU = 2'b00;
    localparam logic [1:0] WDSEL_DM  = 2'b01;
    localparam logic [1:0] WDSEL_PC4 = 2'b10;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_OR  = 2'b10;
    localparam logic [1:0] ALUOP_LUI = 2'b11;

    localparam logic [1:0] EXTOP_ZERO  = 2'b00;
    localparam logic [1:0] EXTOP_SIGN  = 2'b01;
    localparam logic [1:0] EXTOP_UPPER = 2'b10;

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - instruction/flag inputs and datapath controls of the controller
interface mc_ctrl_if;
    logic [31:0] instruction;
    logic        zero;
    logic        PCWr;
    logic [1:0]  NPCSel;
    logic        RegWr;
    logic [1:0]  RegDst;
    logic [1:0]  WDSel;
    logic        ALUSrc;
    logic [1:0]  ALUOp;
    logic [1:0]  ExtOp;
    logic        MemWr;

    // master: the controller; slave: the IFU/datapath side
    modport master (
        input  instruction, zero,
        output PCWr, NPCSel, RegWr, RegDst, WDSel, ALUSrc, ALUOp, ExtOp, MemWr
    );
    modport slave (
        output instruction, zero,
        input  PCWr, NPCSel, RegWr, RegDst, WDSel, ALUSrc, ALUOp, ExtOp, MemWr
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational opcode/funct to instruction-class flags
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic       is_rtype_alu_o,
    output logic       is_subu_o,
    output logic       is_ori_o,
    output logic       is_lw_o,
    output logic       is_sw_o,
    output logic       is_beq_o,
    output logic       is_lui_o,
    output logic       is_j_o,
    output logic       is_jal_o,
    output logic       is_jr_o
);
    logic is_r;

    assign is_r           = (opcode_i == OP_RTYPE);
    assign is_subu_o      = is_r && (funct_i == FN_SUBU);
    assign is_rtype_alu_o = is_r && ((funct_i == FN_ADDU) || (funct_i == FN_SUBU));
    assign is_jr_o        = is_r && (funct_i == FN_JR);
    assign is_ori_o       = (opcode_i == OP_ORI);
    assign is_lw_o        = (opcode_i == OP_LW);
    assign is_sw_o        = (opcode_i == OP_SW);
    assign is_beq_o       = (opcode_i == OP_BEQ);
    assign is_lui_o       = (opcode_i == OP_LUI);
    assign is_j_o         = (opcode_i == OP_J);
    assign is_jal_o       = (opcode_i == OP_JAL);
endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle control FSM; optional counters with CTRL_PERF_CNT_EN
module mc_ctrl
    import mc_ctrl_pkg::*;
`ifdef CTRL_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    mc_ctrl_if.master        bus,
`ifdef CTRL_PERF_CNT_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
`endif
    output logic [2:0]       state
);
    state_t state_q, state_d;

    logic is_rtype_alu, is_subu, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal, is_jr;
    logic is_alu, uses_alu, uses_imm;

    mc_decode u_decode (
        .opcode_i       (bus.instruction[31:26]),
        .funct_i        (bus.instruction[5:0]),
        .is_rtype_alu_o (is_rtype_alu),
        .is_subu_o      (is_subu),
        .is_ori_o       (is_ori),
        .is_lw_o        (is_lw),
        .is_sw_o        (is_sw),
        .is_beq_o       (is_beq),
        .is_lui_o       (is_lui),
        .is_j_o         (is_j),
        .is_jal_o       (is_jal),
        .is_jr_o        (is_jr)
    );

    // Register-writing ALU instructions, and everything that reaches S_EXE
    assign is_alu   = is_rtype_alu || is_ori || is_lui;
    assign uses_alu = is_alu || is_lw || is_sw || is_beq;
    assign uses_imm = is_ori || is_lui || is_lw || is_sw;

    assign state = state_q;

    // State register; reset aborts any instruction straight back to fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    // Next state: each class walks its own sequence and returns to S_IF
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:  state_d = S_ID;
            S_ID:  state_d = uses_alu ? S_EXE : S_IF;
            S_EXE: state_d = (is_lw || is_sw) ? S_MEM : (is_alu ? S_WB : S_IF);
            S_MEM: state_d = is_lw ? S_WB : S_IF;
            S_WB:  state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    // Outputs decoded from state and instruction class; forced idle during reset
    always_comb begin
        bus.PCWr   = 1'b0;
        bus.NPCSel = NPC_SEL_PC4;
        bus.RegWr  = 1'b0;
        bus.RegDst = REGDST_RT;
        bus.WDSel  = WDSEL_ALU;
        bus.ALUSrc = 1'b0;
        bus.ALUOp  = ALUOP_ADD;
        bus.ExtOp  = EXTOP_ZERO;
        bus.MemWr  = 1'b0;
        if (!reset) begin
            // ALU controls stay steady from S_EXE until the instruction retires
            if (uses_alu && (state_q == S_EXE || state_q == S_MEM || state_q == S_WB)) begin
                bus.ALUSrc = uses_imm;
                if (is_subu || is_beq)   bus.ALUOp = ALUOP_SUB;
                else if (is_ori)         bus.ALUOp = ALUOP_OR;
                else if (is_lui)         bus.ALUOp = ALUOP_LUI;
                if (is_lw || is_sw || is_beq) bus.ExtOp = EXTOP_SIGN;
                else if (is_lui)              bus.ExtOp = EXTOP_UPPER;
            end
            case (state_q)
                S_ID: begin
                    if (!uses_alu) begin
                        bus.PCWr = 1'b1;
                        if (is_j || is_jal) bus.NPCSel = NPC_SEL_J;
                        else if (is_jr)     bus.NPCSel = NPC_SEL_REG;
                        if (is_jal) begin
                            bus.RegWr  = 1'b1;
                            bus.RegDst = REGDST_RA;
                            bus.WDSel  = WDSEL_PC4;
                        end
                    end
                end
                S_EXE: begin
                    if (is_beq) begin
                        bus.PCWr   = 1'b1;
                        bus.NPCSel = bus.zero ? NPC_SEL_BEQ : NPC_SEL_PC4;
                    end
                end
                S_MEM: begin
                    if (is_sw) begin
                        bus.PCWr  = 1'b1;
                        bus.MemWr = 1'b1;
                    end
                end
                S_WB: begin
                    bus.PCWr  = 1'b1;
                    bus.RegWr = 1'b1;
                    if (is_rtype_alu) bus.RegDst = REGDST_RD;
                    if (is_lw)        bus.WDSel  = WDSEL_DM;
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    // Free-running cycle and retired-instruction counters, wrapping naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (bus.PCWr) instr_cnt <= instr_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM directly downstream of the IFU.
- Consumes the IFU's combinational instruction word and the ALU zero flag; drives PCWr/NPCSel back to the IFU and enables/selects to GPR, ALU, EXT and DM.
- IFU PC changes only on a PCWr edge, so the instruction word is stable for the whole instruction. PCWr is pulsed exactly once, in the final state of each instruction.

Parameters:
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
instruction  in  32  current instruction from IFU
zero  in  1  ALU equality flag, valid in S_EXE
PCWr  out  1  PC write enable to IFU
NPCSel  out  2  00 PC+4, 01 reg-jmp, 10 j-jmp, 11 beq-jmp
RegWr  out  1  GPR write enable
RegDst  out  2  00 rt, 01 rd, 10 $31
WDSel  out  2  GPR write data: 00 ALU, 01 DM, 10 PC+4
ALUSrc  out  1  0 GPR rt, 1 extended immediate
ALUOp  out  2  00 add, 01 sub, 10 or, 11 lui-pass
ExtOp  out  2  00 zero-ext, 01 sign-ext, 10 upper-16
MemWr  out  1  DM write enable
state  out  3  current state, debug
cycle_cnt  out  CNT_W  only with CTRL_PERF_CNT_EN
instr_cnt  out  CNT_W  only with CTRL_PERF_CNT_EN

Behaviour:
- States: S_IF=0, S_ID=1, S_EXE=2, S_MEM=3, S_WB=4.
- Reset (async) forces S_IF. While in reset, all enables (PCWr, RegWr, MemWr) are 0 and the selects are 0.
- Outputs are decoded from the state plus the opcode/funct of instruction. They are combinational and glitch-free, because instruction is stable between PCWr edges.
- Decode keys: opcode [31:26], funct [5:0].
  - R (op 000000): addu funct 100001, subu 100011, jr 001000.
  - I/J: ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011.
- Sequences (cycles from S_IF to return to S_IF):
  - addu/subu/ori/lui: IF,ID,EXE,WB (4). RegWr=1 and PCWr=1 with NPCSel=00 in WB. RegDst=01 for R-type, 00 otherwise.
  - lw: IF,ID,EXE,MEM,WB (5). ALUSrc=1, ExtOp=01, ALUOp=00. In WB: WDSel=01, RegWr=1, PCWr=1.
  - sw: IF,ID,EXE,MEM (4). MemWr=1 and PCWr=1 (NPCSel=00) in MEM.
  - beq: IF,ID,EXE (3). ALUOp=01 in EXE. PCWr=1 in EXE; NPCSel=11 if zero, else 00.
  - j: IF,ID (2). PCWr=1 with NPCSel=10 in ID.
  - jal: as j, plus RegWr=1, RegDst=10, WDSel=10 in ID.
  - jr: IF,ID (2). PCWr=1 with NPCSel=01 in ID.
- Immediate handling: ori uses ExtOp=00, ALUOp=10. lui uses ExtOp=10, ALUOp=11.
- Unrecognised opcode/funct is treated as a NOP: IF,ID, then PCWr=1 with NPCSel=00 in ID; no RegWr/MemWr.
- Invariants:
  - At most one PCWr pulse per instruction.
  - RegWr and MemWr are never asserted in S_IF.
  - Enables are never asserted in the same cycle as reset.
- Reset asserted mid-instruction aborts immediately to S_IF. No partial write occurs after reset assertion.

Optional Feature:
CTRL_PERF_CNT_EN
- Defined:
  - cycle_cnt increments every non-reset clk.
  - instr_cnt increments on every cycle with PCWr=1.
  - Both reset to 0, are CNT_W bits and wrap modulo 2^CNT_W.
- Undefined: ports and counters absent; no other behaviour changes.

Decomposition:
- Shared package/header holds:
  - state encodings;
  - opcode/funct constants;
  - NPC_SEL_*, REGDST_*, WDSEL_*, ALUOP_*, EXTOP_* constants (NPC_SEL_* must match the IFU's existing values).
- One sub-module: mc_decode. It is purely combinational and maps instruction to per-class flags (is_rtype_alu, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal, is_jr). mc_ctrl holds the FSM and output logic.

Test Plan:
- Reset, then instruction=addu $3,$1,$2 (0x00221821) → states 0,1,2,4; PCWr=1, RegWr=1, RegDst=01, NPCSel=00 only in cycle 4; back in S_IF at cycle 5.
- lw (0x8C220004) → 5-cycle sequence; WB has WDSel=01, RegWr=1, PCWr=1. sw (0xAC220004) → MemWr=1 and PCWr=1 in S_MEM only; RegWr never 1.
- beq (0x10220003) with zero=1 → PCWr=1, NPCSel=11 in S_EXE. With zero=0 → NPCSel=00. Both return to S_IF after 3 cycles.
- j (0x08000042), jal (0x0C000042), jr (0x03E00008) → PCWr in S_ID with NPCSel 10/10/01. jal additionally gives RegWr=1, RegDst=10, WDSel=10.
- Reset asserted in S_MEM of sw → state=0 and MemWr=0 immediately, without waiting for clk. Illegal opcode 0xFC000000 → 2-cycle NOP, PCWr=1 with NPCSel=00.
- With CTRL_PERF_CNT_EN: addu, lw, j after reset → cycle_cnt=11, instr_cnt=3.
